pwl_coeff_loader: RTL and testbench

PWL_COEFF_LOADER -- requirements
Module: pwl_coeff_loader

---
 rtl/pwl_coeff_loader.sv | 133 +++++++++++++
 tb/tb_pwl_coeff_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pwl_coeff_loader.sv
// Streams a PWL coefficient table ({slope, intercept} per segment) into local
// storage, verifies the trailing checksum and serves a registered read port.
module pwl_coeff_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SEG    = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [2*DATA_WIDTH-1:0] rd_data,
  output logic                    busy,
  output logic                    table_valid,
  output logic                    load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SLOPE,
    S_ICPT,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_SEG = ADDR_W'(NUM_SEG - 1);

  state_t                   state;
  logic [ADDR_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]    sum;
  logic signed [DATA_WIDTH-1:0] slope_p0;
  logic [2*DATA_WIDTH-1:0]  coef_mem [NUM_SEG];
  logic                     xfer;
  logic                     wr_en;

  // Checksum is a plain modulo-2^DATA_WIDTH sum; overflow wraps by design.
  function automatic logic [DATA_WIDTH-1:0] sum_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] word
  );
    return acc + word;
  endfunction

  assign xfer  = in_valid && in_ready;
  // Gating with reset keeps an aborted load from landing one last entry.
  assign wr_en = xfer && (state == S_ICPT) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sum         <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      table_valid <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state       <= S_SLOPE;
            cnt         <= '0;
            sum         <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            table_valid <= 1'b0;
            load_error  <= 1'b0;
          end
        end
        S_SLOPE: begin
          if (xfer) begin
            state <= S_ICPT;
            sum   <= sum_add(sum, in_data);
          end
        end
        S_ICPT: begin
          if (xfer) begin
            sum <= sum_add(sum, in_data);
            cnt <= cnt + ADDR_W'(1);
            state <= (cnt == LAST_SEG) ? S_CSUM : S_SLOPE;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == sum) begin
              state       <= S_DONE;
              table_valid <= 1'b1;
            end else begin
              state       <= S_ERR;
              load_error  <= 1'b1;
              table_valid <= 1'b0;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0: slope held until its intercept arrives so the entry is written atomically.
  always_ff @(posedge clk) begin
    if (xfer && (state == S_SLOPE)) begin
      slope_p0 <= signed'(in_data);
    end
  end

  // Table storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      coef_mem[cnt] <= {slope_p0, in_data};
    end
  end

  // Read stage: old contents are returned on a same-cycle read/write collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= coef_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_pwl_coeff_loader.sv
// Directed bench for pwl_coeff_loader: good/bad/wrapping loads, stalls,
// mid-load reset, ignored start, and read-port collision behaviour.
module tb_pwl_coeff_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        table_valid;
  logic        load_error;

  int checks = 0;
  int errors = 0;

  pwl_coeff_loader #(.DATA_WIDTH(16), .NUM_SEG(64), .ADDR_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .table_valid(table_valid),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // kind 0: 0x1000/0x0000, kind 1: ramp, kind 2: all ones
  function automatic logic [15:0] word_of(input int kind, input int w);
    int idx;
    idx = w / 2;
    case (kind)
      0: word_of = (w % 2 == 0) ? 16'h1000 : 16'h0000;
      1: word_of = (w % 2 == 0) ? 16'(idx) : 16'(16'h0100 + idx);
      default: word_of = 16'hFFFF;
    endcase
  endfunction

  task automatic push(input logic [15:0] w, input int gap, input logic with_start);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    start    = with_start;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check_eq(tag, rd_data, exp);
  endtask

  task automatic do_load(input int kind, input logic [15:0] csum, input int stall,
                         input int nwords, input int start_at, input int probe);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      push((w < 128) ? word_of(kind, w) : csum,
           (stall != 0) ? int'($urandom_range(0, 3)) : 0,
           (w == start_at) ? 1'b1 : 1'b0);
      if (probe != 0 && w == 15) begin
        check_eq("collide_old", rd_data, 32'h1000_0000);
        @(posedge clk);
        #1;
        check_eq("collide_new", rd_data, 32'h0007_0107);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rd_addr  = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_tvalid", 32'(table_valid), 32'd0);
    check_eq("rst_lerr", 32'(load_error), 32'd0);
    check_eq("rst_rdata", rd_data, 32'd0);
    reset = 1'b0;

    // Stray in_valid in IDLE must not start anything.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    repeat (3) @(negedge clk);
    check_eq("idle_ready", 32'(in_ready), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // Good load
    do_load(0, 16'h0000, 0, 129, -1, 0);
    @(negedge clk);
    check_eq("good_tvalid", 32'(table_valid), 32'd1);
    check_eq("good_lerr", 32'(load_error), 32'd0);
    check_eq("good_busy", 32'(busy), 32'd0);
    check_eq("good_ready", 32'(in_ready), 32'd0);
    rd_check("good_rd5", 6'd5, 32'h1000_0000);

    // Bad checksum; table_valid must drop as soon as the load starts
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("bad_start_tvalid", 32'(table_valid), 32'd0);
    check_eq("bad_start_busy", 32'(busy), 32'd1);
    check_eq("bad_start_ready", 32'(in_ready), 32'd1);
    for (int w = 0; w < 129; w++) push((w < 128) ? word_of(0, w) : 16'h0001, 0, 1'b0);
    @(negedge clk);
    check_eq("bad_lerr", 32'(load_error), 32'd1);
    check_eq("bad_tvalid", 32'(table_valid), 32'd0);
    check_eq("bad_busy", 32'(busy), 32'd0);
    rd_check("bad_rd63", 6'd63, 32'h1000_0000);

    // Ramp with random stalls; checksum = 2016 + (64*0x100 + 2016) = 0x4FC0
    @(negedge clk);
    rd_addr = 6'd7;
    do_load(1, 16'h4FC0, 1, 129, -1, 1);
    @(negedge clk);
    check_eq("ramp_tvalid", 32'(table_valid), 32'd1);
    check_eq("ramp_lerr", 32'(load_error), 32'd0);
    for (int i = 0; i < 64; i++)
      rd_check($sformatf("ramp_rd%0d", i), 6'(i), {16'(i), 16'(16'h0100 + i)});

    // in_valid after DONE is ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check_eq("done_ign_tvalid", 32'(table_valid), 32'd1);
    check_eq("done_ign_busy", 32'(busy), 32'd0);
    rd_check("done_ign_rd0", 6'd0, 32'h0000_0100);

    // Wrap: 128 x 0xFFFF sums to 0xFF80 mod 2^16
    do_load(2, 16'hFF80, 0, 129, -1, 0);
    @(negedge clk);
    check_eq("wrap_tvalid", 32'(table_valid), 32'd1);
    check_eq("wrap_lerr", 32'(load_error), 32'd0);
    rd_check("wrap_rd0", 6'd0, 32'hFFFF_FFFF);

    // Reset after 40 words: entries 0..19 rewritten, 20 untouched
    do_load(0, 16'h0000, 0, 40, -1, 0);
    @(negedge clk);
    check_eq("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(in_ready), 32'd0);
    check_eq("abort_tvalid", 32'(table_valid), 32'd0);
    rd_check("abort_rd19", 6'd19, 32'h1000_0000);
    rd_check("abort_rd20", 6'd20, 32'hFFFF_FFFF);
    do_load(1, 16'h4FC0, 0, 129, -1, 0);
    @(negedge clk);
    check_eq("reload_tvalid", 32'(table_valid), 32'd1);
    rd_check("reload_rd20", 6'd20, 32'h0014_0114);

    // start at word 10 while busy must be ignored
    do_load(0, 16'h0000, 0, 129, 10, 0);
    @(negedge clk);
    check_eq("midstart_tvalid", 32'(table_valid), 32'd1);
    check_eq("midstart_lerr", 32'(load_error), 32'd0);
    rd_check("midstart_rd63", 6'd63, 32'h1000_0000);
    rd_check("midstart_rd5", 6'd5, 32'h1000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
